// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter.
package rf_wb_arbiter_pkg;

  localparam int RF_NREG = 32;
  localparam int RF_AW   = 5;
  localparam int RF_DW   = 32;

  // Architectural zero register: never written, never reserved.
  localparam int REG_ZERO = 0;

endpackage

// File: rtl/rf_wb_arbiter_scoreboard.sv
// Pending-write scoreboard for long-latency destinations.
// Holds one busy bit per register; a reservation and a release of the same
// register in one cycle resolve in favour of the reservation.
module rf_scoreboard
  import rf_wb_arbiter_pkg::*;
#(
  parameter int NREG = RF_NREG,
  parameter int AW   = RF_AW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_iss_valid,
  input  logic [AW-1:0]   i_iss_addr,
  output logic            o_iss_ready,
  input  logic            i_clr_valid,
  input  logic [AW-1:0]   i_clr_addr,
  input  logic [AW-1:0]   i_q_a1,
  input  logic [AW-1:0]   i_q_a2,
  output logic            o_q_hazard,
  output logic [NREG-1:0] o_busy
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_clr;
  logic [NREG-1:0] w_busy_nxt;
  logic            w_set_en;

  assign o_iss_ready = ~r_busy[i_iss_addr];
  assign w_set_en    = i_iss_valid & o_iss_ready;
  assign o_q_hazard  = r_busy[i_q_a1] | r_busy[i_q_a2];
  assign o_busy      = r_busy;

  // Next busy vector: release first, then reservation on top so set wins.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (w_set_en && (i_iss_addr != AW'(REG_ZERO))) w_set[i_iss_addr] = 1'b1;
    if (i_clr_valid) w_clr[i_clr_addr] = 1'b1;
    w_busy_nxt = (r_busy & ~w_clr) | w_set;
    w_busy_nxt[REG_ZERO] = 1'b0;
  end

  // Busy vector register.
  always_ff @(posedge clk) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_nxt;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter between the main pipeline writeback (s0)
// and the multi-cycle unit (s1), with starvation guard for s1 and a
// scoreboard of outstanding s1 destinations for decode hazard checks.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int NREG       = RF_NREG,
  parameter int AW         = RF_AW,
  parameter int DW         = RF_DW,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s0_valid,
  input  logic [AW-1:0]   s0_addr,
  input  logic [DW-1:0]   s0_data,
  output logic            s0_ready,
  input  logic            s1_valid,
  input  logic [AW-1:0]   s1_addr,
  input  logic [DW-1:0]   s1_data,
  output logic            s1_ready,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_addr,
  output logic            iss_ready,
  input  logic [AW-1:0]   q_a1,
  input  logic [AW-1:0]   q_a2,
  output logic            q_hazard,
  output logic [NREG-1:0] busy,
  output logic            rf_we,
  output logic [AW-1:0]   rf_wa,
  output logic [DW-1:0]   rf_wd
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] r_starve;
  logic          r_rf_we;
  logic [AW-1:0] r_rf_wa;
  logic [DW-1:0] r_rf_wd;

  logic          w_s1_pri;
  logic          w_gnt;
  logic [AW-1:0] w_gnt_addr;
  logic [DW-1:0] w_gnt_data;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v == SW'(STARVE_MAX)) ? v : v + 1'b1;
  endfunction

  // s1 takes the port either when s0 is idle or once it has waited long enough.
  assign w_s1_pri   = s1_valid && (r_starve == SW'(STARVE_MAX));
  assign s0_ready   = s0_valid && !w_s1_pri;
  assign s1_ready   = s1_valid && (w_s1_pri || !s0_valid);
  assign w_gnt      = s0_ready || s1_ready;
  assign w_gnt_addr = s1_ready ? s1_addr : s0_addr;
  assign w_gnt_data = s1_ready ? s1_data : s0_data;

  // Starvation counter: counts consecutive denied s1 requests.
  always_ff @(posedge clk) begin
    if (rst)                      r_starve <= '0;
    else if (s1_valid && !s1_ready) r_starve <= sat_inc(r_starve);
    else                          r_starve <= '0;
  end

  // ---- stage boundary: granted write registered toward the register file ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rf_we <= 1'b0;
      r_rf_wa <= '0;
      r_rf_wd <= '0;
    end else if (w_gnt) begin
      r_rf_we <= (w_gnt_addr != AW'(REG_ZERO));
      r_rf_wa <= w_gnt_addr;
      r_rf_wd <= w_gnt_data;
    end else begin
      r_rf_we <= 1'b0;
    end
  end

  assign rf_we = r_rf_we;
  assign rf_wa = r_rf_wa;
  assign rf_wd = r_rf_wd;

  rf_scoreboard #(
    .NREG (NREG),
    .AW   (AW)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .i_iss_valid (iss_valid),
    .i_iss_addr  (iss_addr),
    .o_iss_ready (iss_ready),
    .i_clr_valid (s1_ready),
    .i_clr_addr  (s1_addr),
    .i_q_a1      (q_a1),
    .i_q_a2      (q_a2),
    .o_q_hazard  (q_hazard),
    .o_busy      (busy)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed vector table, a
// reset-during-operation sequence, and randomized traffic against a model.
module tb_rf_wb_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        s0_valid, s1_valid, iss_valid;
  logic [4:0]  s0_addr, s1_addr, iss_addr, q_a1, q_a2;
  logic [31:0] s0_data, s1_data;
  logic        s0_ready, s1_ready, iss_ready, q_hazard;
  logic [31:0] busy;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.NREG(32), .AW(5), .DW(32), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_addr(s0_addr), .s0_data(s0_data), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_addr(s1_addr), .s1_data(s1_data), .s1_ready(s1_ready),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready),
    .q_a1(q_a1), .q_a2(q_a2), .q_hazard(q_hazard), .busy(busy),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  bit          m_busy[32];
  int          m_starve;
  bit          m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  logic        c_s1r;

  function automatic logic [31:0] m_busy_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  // One clock cycle: compare combinational outputs, advance the model,
  // then compare registered outputs just after the edge.
  task automatic step();
    bit g0, g1, ir, hz;
    #4;
    g1 = s1_valid && (m_starve >= STARVE_MAX || !s0_valid);
    g0 = s0_valid && !g1;
    ir = !m_busy[iss_addr];
    hz = m_busy[q_a1] || m_busy[q_a2];
    c_s1r = s1_ready;
    if (!rst) begin
      chk("s0_ready", 64'(s0_ready), 64'(g0));
      chk("s1_ready", 64'(s1_ready), 64'(g1));
      chk("iss_ready", 64'(iss_ready), 64'(ir));
      chk("q_hazard", 64'(q_hazard), 64'(hz));
    end
    if (rst) begin
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_starve = 0; m_we = 1'b0; m_wa = '0; m_wd = '0;
    end else begin
      if (g0 || g1) begin
        m_wa = g1 ? s1_addr : s0_addr;
        m_wd = g1 ? s1_data : s0_data;
        m_we = (m_wa != 0);
      end else begin
        m_we = 1'b0;
      end
      if (s1_valid && !g1) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
      else                 m_starve = 0;
      if (g1) m_busy[s1_addr] = 1'b0;
      if (iss_valid && ir && iss_addr != 0) m_busy[iss_addr] = 1'b1;
    end
    @(posedge clk); #1;
    chk("rf_we", 64'(rf_we), 64'(m_we));
    chk("busy", 64'(busy), 64'(m_busy_vec()));
    if (m_we) begin
      chk("rf_wa", 64'(rf_wa), 64'(m_wa));
      chk("rf_wd", 64'(rf_wd), 64'(m_wd));
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst, s0v;
    logic [4:0]  s0a;
    logic [31:0] s0d;
    logic        s1v;
    logic [4:0]  s1a;
    logic [31:0] s1d;
    logic        iv;
    logic [4:0]  ia, a1, a2;
    logic        e_s0r, e_s1r, e_ir, e_hz, e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd, e_busy;
    logic        cd;
  } vec_t;

  vec_t tv[19];

  initial begin
    rst = 1'b1; s0_valid = 0; s0_addr = 0; s0_data = 0;
    s1_valid = 0; s1_addr = 0; s1_data = 0;
    iss_valid = 0; iss_addr = 0; q_a1 = 0; q_a2 = 0;

    //          rst s0v s0a s0d            s1v s1a s1d           iv ia a1 a2  s0r s1r ir hz  we wa wd            busy    cd
    tv[0]  = '{1, 1, 5, 32'h55,        0, 0, 32'h0,         0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 32'h0,        32'h0,   1};
    tv[1]  = '{1, 1, 5, 32'h55,        0, 0, 32'h0,         0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 32'h0,        32'h0,   1};
    tv[2]  = '{0, 1, 5, 32'h55,        0, 0, 32'h0,         0, 0, 0, 0,  1, 0, 1, 0,  1, 5, 32'h55,       32'h0,   1};
    tv[3]  = '{0, 1, 1, 32'h11,        1, 2, 32'h22,        0, 0, 0, 0,  1, 0, 1, 0,  1, 1, 32'h11,       32'h0,   1};
    tv[4]  = '{0, 1, 1, 32'h11,        1, 2, 32'h22,        0, 0, 0, 0,  1, 0, 1, 0,  1, 1, 32'h11,       32'h0,   1};
    tv[5]  = '{0, 1, 1, 32'h11,        1, 2, 32'h22,        0, 0, 0, 0,  1, 0, 1, 0,  1, 1, 32'h11,       32'h0,   1};
    tv[6]  = '{0, 1, 1, 32'h11,        1, 2, 32'h22,        0, 0, 0, 0,  1, 0, 1, 0,  1, 1, 32'h11,       32'h0,   1};
    tv[7]  = '{0, 1, 1, 32'h11,        1, 2, 32'h22,        0, 0, 0, 0,  0, 1, 1, 0,  1, 2, 32'h22,       32'h0,   1};
    tv[8]  = '{0, 1, 1, 32'h11,        1, 2, 32'h22,        0, 0, 0, 0,  1, 0, 1, 0,  1, 1, 32'h11,       32'h0,   1};
    tv[9]  = '{0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 8, 8, 0,  0, 0, 1, 0,  0, 1, 32'h11,       32'h100, 1};
    tv[10] = '{0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 8, 8, 0,  0, 0, 0, 1,  0, 1, 32'h11,       32'h100, 1};
    tv[11] = '{0, 0, 0, 32'h0,         1, 8, 32'hDEADBEEF,  0, 0, 8, 0,  0, 1, 1, 1,  1, 8, 32'hDEADBEEF, 32'h0,   1};
    tv[12] = '{0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 8, 0,  0, 0, 1, 0,  0, 8, 32'hDEADBEEF, 32'h0,   1};
    tv[13] = '{0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 3, 0, 3,  0, 0, 1, 0,  0, 8, 32'hDEADBEEF, 32'h8,   1};
    tv[14] = '{0, 0, 0, 32'h0,         1, 3, 32'h33,        1, 3, 0, 3,  0, 1, 0, 1,  1, 3, 32'h33,       32'h0,   1};
    tv[15] = '{0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 3, 0, 3,  0, 0, 1, 0,  0, 3, 32'h33,       32'h8,   1};
    tv[16] = '{0, 0, 0, 32'h0,         1, 3, 32'h34,        1, 4, 0, 3,  0, 1, 1, 1,  1, 3, 32'h34,       32'h10,  1};
    tv[17] = '{0, 1, 0, 32'h12345678,  0, 0, 32'h0,         1, 0, 4, 0,  1, 0, 1, 1,  0, 0, 32'h0,        32'h10,  0};
    tv[18] = '{0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 0,  0, 0, 1, 0,  0, 0, 32'h0,        32'h10,  0};

    #1;
    for (int i = 0; i < 19; i++) begin
      rst = tv[i].rst;
      s0_valid = tv[i].s0v; s0_addr = tv[i].s0a; s0_data = tv[i].s0d;
      s1_valid = tv[i].s1v; s1_addr = tv[i].s1a; s1_data = tv[i].s1d;
      iss_valid = tv[i].iv; iss_addr = tv[i].ia; q_a1 = tv[i].a1; q_a2 = tv[i].a2;
      #4;
      if (!tv[i].rst) begin
        chk($sformatf("vec%0d.s0_ready", i), 64'(s0_ready), 64'(tv[i].e_s0r));
        chk($sformatf("vec%0d.s1_ready", i), 64'(s1_ready), 64'(tv[i].e_s1r));
        chk($sformatf("vec%0d.iss_ready", i), 64'(iss_ready), 64'(tv[i].e_ir));
        chk($sformatf("vec%0d.q_hazard", i), 64'(q_hazard), 64'(tv[i].e_hz));
      end
      @(posedge clk); #1;
      chk($sformatf("vec%0d.rf_we", i), 64'(rf_we), 64'(tv[i].e_we));
      chk($sformatf("vec%0d.busy", i), 64'(busy), 64'(tv[i].e_busy));
      if (tv[i].cd) begin
        chk($sformatf("vec%0d.rf_wa", i), 64'(rf_wa), 64'(tv[i].e_wa));
        chk($sformatf("vec%0d.rf_wd", i), 64'(rf_wd), 64'(tv[i].e_wd));
      end
    end

    // ---------------- reset in the middle of activity ----------------
    rst = 1'b1; s0_valid = 0; s1_valid = 0; iss_valid = 0;
    step();
    rst = 1'b0;
    for (int k = 8; k < 12; k++) begin
      s0_valid = 1; s0_addr = 1; s0_data = 32'(k);
      iss_valid = 1; iss_addr = 5'(k);
      step();
    end
    iss_valid = 0;
    s1_valid = 1; s1_addr = 2; s1_data = 32'hA5A5;
    for (int k = 0; k < 3; k++) step();
    chk("midrst.busy_before", 64'(busy), 64'h0000_0F00);
    rst = 1'b1;
    step();
    chk("midrst.busy_after", 64'(busy), 64'h0);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("midrst.s1_grant%0d", k), 64'(c_s1r), 64'(k == 4));
    end

    // ---------------- randomized traffic ----------------
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 99) == 0);
      s0_valid  = $urandom_range(0, 1);
      s0_addr   = 5'($urandom_range(0, 7));
      s0_data   = $urandom;
      s1_valid  = ($urandom_range(0, 3) != 0);
      s1_addr   = 5'($urandom_range(0, 7));
      s1_data   = $urandom;
      iss_valid = $urandom_range(0, 1);
      iss_addr  = 5'($urandom_range(0, 7));
      q_a1      = 5'($urandom_range(0, 7));
      q_a2      = 5'($urandom_range(0, 31));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port (RFWr/A3/WD) between two writeback sources.
- Source 0 is the main pipeline writeback; source 1 is the multi-cycle unit (mul/div, future load unit).
- Keeps a 32-bit pending-write scoreboard for source-1 destinations and answers RAW hazard queries for the two decode read addresses (A1/A2).
- Sits between the writeback stage and the register file; drives the RF write inputs from registers.

Parameters:
- NREG, 32, number of architectural registers (scoreboard width).
- AW, 5, register address width.
- DW, 32, data width.
- STARVE_MAX, 4, consecutive cycles source 1 may be denied before it takes priority for one grant.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- s0_valid  in  1  source 0 write request.
- s0_addr  in  AW  source 0 destination register.
- s0_data  in  DW  source 0 write data.
- s0_ready  out  1  source 0 request accepted this cycle (combinational).
- s1_valid  in  1  source 1 write request.
- s1_addr  in  AW  source 1 destination register.
- s1_data  in  DW  source 1 write data.
- s1_ready  out  1  source 1 request accepted this cycle (combinational).
- iss_valid  in  1  long-latency op issued; reserve iss_addr.
- iss_addr  in  AW  destination register of the issued op.
- iss_ready  out  1  reservation accepted (combinational).
- q_a1  in  AW  decode read address 1.
- q_a2  in  AW  decode read address 2.
- q_hazard  out  1  either queried register is pending (combinational).
- busy  out  NREG  scoreboard bit vector (registered).
- rf_we  out  1  RFWr to the register file (registered).
- rf_wa  out  AW  A3 to the register file (registered).
- rf_wd  out  DW  WD to the register file (registered).

Behaviour:
- Reset: rf_we=0, rf_wa=0, rf_wd=0, busy=0, starve counter=0. Reset wins over every same-cycle request. A request in flight at reset is dropped, not replayed.
- Grant is combinational in the same cycle:
  - Default priority is source 0.
  - If s1_valid and starve count == STARVE_MAX, source 1 wins and s0_ready=0.
  - At most one ready is high per cycle.
  - A ready is never high without the matching valid.
- Starve counter:
  - Increments (saturating at STARVE_MAX) when s1_valid is high and s1 is not granted.
  - Clears on an s1 grant, or when s1_valid is low.
- Write latency is one cycle. On posedge, if a grant occurred: rf_we=1, rf_wa and rf_wd take the granted address and data. Otherwise rf_we=0 and rf_wa/rf_wd hold their values.
- Register 0:
  - A granted write with addr 0 is acknowledged (ready=1) but gives rf_we=0.
  - busy[0] is constant 0; iss_addr=0 is always accepted with no effect.
- Scoreboard:
  - iss_ready = ~busy[iss_addr]. If iss_valid and iss_ready, busy[iss_addr] is set on the next edge.
  - An s1 grant clears busy[s1_addr] on the next edge.
  - Set and clear of the same register in one cycle: set wins (new reservation supersedes).
  - An s0 grant never touches the scoreboard.
  - An s1 write to a non-busy register is still performed.
- q_hazard = busy[q_a1] | busy[q_a2], from the registered busy. The bypass of a same-cycle grant is the forwarding unit's responsibility.
- s0 and s1 targeting the same register in the same cycle: only the granted one writes; the other retries. No merging.

Decomposition:
- Shared package: AW, DW, NREG, and constant REG_ZERO=0.
- One natural sub-module: rf_scoreboard, which holds the busy vector and implements set/clear priority, iss_ready and q_hazard.
- Arbitration, starve counter and output registers stay in the top module.

Test Plan:
- Reset:
  - Stimulus: rst=1 for 2 cycles with s0_valid=1, s0_addr=5.
  - Required: rf_we=0, busy=0. After release, the first grant gives rf_we=1, rf_wa=5 one cycle later.
- Priority and starvation (STARVE_MAX=4):
  - Stimulus: s0 and s1 both valid continuously.
  - Required: s0 is granted 4 cycles, s1 on the 5th, then the pattern repeats. rf_wa follows the winning source with 1-cycle latency.
- Scoreboard:
  - Stimulus: issue reg 8, then query q_a1=8.
  - Required: q_hazard=1 and iss_ready=0 for a second issue to reg 8. An s1 write to 8 (data 0xDEADBEEF) gives rf_wd=0xDEADBEEF and busy[8]=0 on the next edge.
- Simultaneous set and clear:
  - Stimulus: s1 is granted for reg 3 in the same cycle a new issue to reg 3 arrives (busy[3] was 1, so iss_ready=0 and there is no set).
  - Stimulus, second case: clear of reg 3 in the same cycle as issue of reg 4.
  - Required: busy[3]=0, busy[4]=1.
- Register 0:
  - Stimulus: s0 write addr 0, data 0x12345678.
  - Required: s0_ready=1, rf_we stays 0. Issue to reg 0 leaves busy=0.
- Reset mid-operation:
  - Stimulus: busy=0x00000F00 and starve count=3, then rst.
  - Required: busy=0, counter=0. s1 is not granted until after 4 new denials.
